// File: rtl/cmsdk_mtx_input_stage_if.sv
// cmsdk_mtx_input_stage_if: master-side AHB signals plus the arbiter-facing request bus of one matrix input port
interface cmsdk_mtx_input_stage_if #(parameter int ADDR_WIDTH = 32);
   logic                  HSELS;
   logic [ADDR_WIDTH-1:0] HADDRS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;
   logic                  HREADYOUTS;
   logic                  HRESPS;
   logic                  req_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic [1:0]            trans_o;
   logic                  write_o;
   logic [2:0]            size_o;
   logic [2:0]            burst_o;
   logic [3:0]            prot_o;
   logic                  mastlock_o;
   logic                  addr_accept_i;
   logic                  readyout_i;
   logic                  resp_i;
   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
      input  addr_accept_i, readyout_i, resp_i,
      output HREADYOUTS, HRESPS, req_o, addr_o, trans_o, write_o, size_o, burst_o, prot_o, mastlock_o
   );
   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
      output addr_accept_i, readyout_i, resp_i,
      input  HREADYOUTS, HRESPS, req_o, addr_o, trans_o, write_o, size_o, burst_o, prot_o, mastlock_o
   );
endinterface

// File: rtl/cmsdk_mtx_input_stage.sv
// cmsdk_mtx_input_stage: holds an address phase the matrix cannot take yet and stalls the master until it completes
module cmsdk_mtx_input_stage #(
   parameter int ADDR_WIDTH  = 32,
   parameter bit CONVERT_SEQ = 1'b1
) (
   input logic                      HCLK,
   input logic                      HRESETn,
   cmsdk_mtx_input_stage_if.slave   bus
);
   typedef enum logic {PASS = 1'b0, HOLD = 1'b1} state_t;
   state_t                state_q, state_d;
   logic                  dphase_q, dphase_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            trans_q, trans_d;
   logic                  write_q, write_d;
   logic [2:0]            size_q, size_d;
   logic [2:0]            burst_q, burst_d;
   logic [3:0]            prot_q, prot_d;
   logic                  lock_q, lock_d;
   logic                  hold, new_tran, capture, seq_conv;
   assign hold     = state_q == HOLD;
   assign new_tran = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
   assign seq_conv = CONVERT_SEQ & hold & (trans_q == 2'b11);
   assign bus.req_o      = hold | new_tran;
   assign bus.addr_o     = hold ? addr_q : bus.HADDRS;
   assign bus.trans_o    = seq_conv ? 2'b10 : hold ? trans_q : bus.HTRANSS;
   assign bus.write_o    = hold ? write_q : bus.HWRITES;
   assign bus.size_o     = hold ? size_q : bus.HSIZES;
   assign bus.burst_o    = seq_conv ? 3'b001 : hold ? burst_q : bus.HBURSTS;
   assign bus.prot_o     = hold ? prot_q : bus.HPROTS;
   assign bus.mastlock_o = hold ? lock_q : bus.HMASTLOCKS;
   assign bus.HREADYOUTS = dphase_q ? bus.readyout_i : !hold;
   assign bus.HRESPS     = dphase_q & bus.resp_i;
   // next state: capture an unaccepted transfer, leave HOLD on accept, track the outstanding data phase
   always_comb begin
      capture  = !hold & new_tran & !bus.addr_accept_i;
      state_d  = hold ? (bus.addr_accept_i ? PASS : HOLD) : (capture ? HOLD : PASS);
      dphase_d = (bus.req_o & bus.addr_accept_i) | (dphase_q & !bus.readyout_i);
      addr_d   = capture ? bus.HADDRS : addr_q;
      trans_d  = capture ? bus.HTRANSS : trans_q;
      write_d  = capture ? bus.HWRITES : write_q;
      size_d   = capture ? bus.HSIZES : size_q;
      burst_d  = capture ? bus.HBURSTS : burst_q;
      prot_d   = capture ? bus.HPROTS : prot_q;
      lock_d   = capture ? bus.HMASTLOCKS : lock_q;
   end
   // state and holding registers; reset abandons any held or in-flight transfer
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state_q  <= PASS;
         dphase_q <= 1'b0;
         addr_q   <= '0;
         trans_q  <= '0;
         write_q  <= 1'b0;
         size_q   <= '0;
         burst_q  <= '0;
         prot_q   <= '0;
         lock_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dphase_q <= dphase_d;
         addr_q   <= addr_d;
         trans_q  <= trans_d;
         write_q  <= write_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         prot_q   <= prot_d;
         lock_q   <= lock_d;
      end
endmodule
